seg_scan_display: RTL and testbench
===================================

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 1024: clkDis cycles per digit slot; SHALL be a multiple of 16, minimum 16.
REQ-003 Parameter BLINK_FRAMES, default 64: full scan frames per blink half-period, minimum 1.
REQ-004 clkDis  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 digits  input  4*NUM_DIGITS  hex value per digit; digit i = digits[4i+3:4i].
REQ-007 dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-008 blank  input  NUM_DIGITS  1 = digit i never lit.
REQ-009 blink_en  input  NUM_DIGITS  1 = digit i is blanked during the blink-off phase.
REQ-010 brightness  input  4  duty level 0..15; 15 = full on.
REQ-011 seg  output  7  active-low segments, seg[0]=a .. seg[6]=g.
REQ-012 dp  output  1  active-low decimal point.
REQ-013 an  output  NUM_DIGITS  active-low anodes; an[i] drives digit i.
REQ-014 frame_done  output  1  one-cycle pulse per completed scan frame.

Function
REQ-015 Prescaler cnt counts 0..SCAN_DIV-1 and wraps to 0; tick = (cnt == SCAN_DIV-1).
REQ-016 Digit index idx advances by 1 on tick; wraps from NUM_DIGITS-1 to 0; NUM_DIGITS=1 keeps idx at 0.
REQ-017 Duty phase = cnt / (SCAN_DIV/16), range 0..15; digit enabled when phase <= brightness (brightness 0 = 1/16 duty).
REQ-018 Blink counter counts frame ends 0..BLINK_FRAMES-1; at the frame end with count BLINK_FRAMES-1 it wraps and blink_off toggles.
REQ-019 Digit idx lit iff enabled AND blank[idx]==0 AND NOT (blink_en[idx] AND blink_off).
REQ-020 Lit: an = all ones except an[idx]=0; seg = hex decode of digit idx; dp = ~dp_in[idx].
REQ-021 Unlit: an all ones, seg = 7'b1111111, dp = 1.
REQ-022 Hex decode (gfedcba, active-low): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
REQ-023 seg, dp, an, frame_done are registered; they reflect cnt/idx/blink_off and inputs sampled in the previous cycle (latency 1).
REQ-024 frame_done = 1 in the cycle after a tick with idx == NUM_DIGITS-1; 0 otherwise.
REQ-025 At most one an bit is low in any cycle; anodes never overlap across slot changes.
REQ-026 Input changes take effect 1 cycle after sampling, mid-slot included; no input latching per slot.

Reset
REQ-027 rst_n low asynchronously forces cnt=0, idx=0, blink counter=0, blink_off=0, an=all ones, seg=7'b1111111, dp=1, frame_done=0.
REQ-028 Reset asserted mid-slot or mid-frame takes effect immediately; first edge after release starts at slot 0, cnt 0, blink-on phase.

Verification (NUM_DIGITS=4, SCAN_DIV=16, BLINK_FRAMES=2 unless noted)
REQ-029 Reset: pulse rst_n low mid-frame -> an=4'b1111, seg=7'h7F, dp=1 immediately; first lit output is digit 0.
REQ-030 Scan: digits=16'h1A90, brightness=15 -> an 1110/seg 1000000 (16 cycles), 1101/0010000, 1011/0001000, 0111/1111001; frame_done pulses every 64 cycles.
REQ-031 Dimming: brightness=3 -> each anode low 4 of 16 cycles (cnt 0..3, observed 1 cycle later), high for remainder.
REQ-032 Blink: blink_en=4'b0010 -> digit 1 lit frames 0-1, dark frames 2-3, lit frames 4-5; other digits unaffected.
REQ-033 Blank/dp: blank=4'b0100, dp_in=4'b0001 -> slot 2 an=1111; slot 0 dp=0; all others dp=1.
REQ-034 NUM_DIGITS=1, SCAN_DIV=32: an toggles only by duty; frame_done pulses every 32 cycles.

Source files
------------

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scanner with per-digit blanking, blinking and PWM brightness.
// All outputs are registered and reflect the scan state of the previous cycle.
module seg_scan_display #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 1024,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                    clkDis,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic [3:0]              brightness,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);
    localparam int unsigned CNT_W     = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BLK_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned PHASE_DIV = SCAN_DIV / 16;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BLK_W-1:0]      blink_cnt_q, blink_cnt_d;
    logic                  blink_off_q, blink_off_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_done_q;

    logic                  tick, frame_end, lit;
    logic [CNT_W-1:0]      phase_full;
    logic [3:0]            phase;
    logic [3:0]            cur_hex;
    logic [6:0]            cur_seg;

    assign tick       = (cnt_q == CNT_W'(SCAN_DIV - 1));
    assign frame_end  = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign phase_full = cnt_q / CNT_W'(PHASE_DIV);
    assign phase      = phase_full[3:0];

    always_comb begin
        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        idx_d       = idx_q;
        blink_cnt_d = blink_cnt_q;
        blink_off_d = blink_off_q;
        if (tick) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        if (frame_end) begin
            if (blink_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        cur_hex = digits[{idx_q, 2'b00} +: 4];
        case (cur_hex)
            4'h0:    cur_seg = 7'b1000000;
            4'h1:    cur_seg = 7'b1111001;
            4'h2:    cur_seg = 7'b0100100;
            4'h3:    cur_seg = 7'b0110000;
            4'h4:    cur_seg = 7'b0011001;
            4'h5:    cur_seg = 7'b0010010;
            4'h6:    cur_seg = 7'b0000010;
            4'h7:    cur_seg = 7'b1111000;
            4'h8:    cur_seg = 7'b0000000;
            4'h9:    cur_seg = 7'b0010000;
            4'hA:    cur_seg = 7'b0001000;
            4'hB:    cur_seg = 7'b0000011;
            4'hC:    cur_seg = 7'b1000110;
            4'hD:    cur_seg = 7'b0100001;
            4'hE:    cur_seg = 7'b0000110;
            default: cur_seg = 7'b0001110;
        endcase
    end

    // Anodes are decoded from a single idx, so at most one can be low per cycle.
    always_comb begin
        lit  = (phase <= brightness) && !blank[idx_q] && !(blink_en[idx_q] && blink_off_q);
        an_d = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        seg_d = lit ? cur_seg : 7'h7F;
        dp_d  = lit ? ~dp_in[idx_q] : 1'b1;
    end

    always_ff @(posedge clkDis or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            blink_cnt_q  <= '0;
            blink_off_q  <= 1'b0;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_off_q  <= blink_off_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_end;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Randomized bench for seg_scan_display: a 4-digit/16-div instance and a 1-digit/32-div
// instance checked against an arithmetic model indexed by cycles since reset release.
module tb_seg_scan_display;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits = 16'h1A90;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank = '0;
    logic [3:0]  blink_en = '0;
    logic [3:0]  brightness = 4'hF;

    logic [6:0]  seg0, seg1;
    logic        dp0, dp1, fd0, fd1;
    logic [3:0]  an0;
    logic [0:0]  an1;

    int          vectors = 0;
    int          miscompares = 0;
    int          n = 0;
    logic [16:0] e0, e1, o0, o1;
    logic [6:0]  hex_tab [16];

    always #5 clk = ~clk;

    seg_scan_display #(.NUM_DIGITS(4), .SCAN_DIV(16), .BLINK_FRAMES(2)) dut4 (
        .clkDis(clk), .rst_n(rst_n), .digits(digits), .dp_in(dp_in), .blank(blank),
        .blink_en(blink_en), .brightness(brightness), .seg(seg0), .dp(dp0), .an(an0),
        .frame_done(fd0)
    );

    seg_scan_display #(.NUM_DIGITS(1), .SCAN_DIV(32), .BLINK_FRAMES(2)) dut1 (
        .clkDis(clk), .rst_n(rst_n), .digits(digits[3:0]), .dp_in(dp_in[0:0]),
        .blank(blank[0:0]), .blink_en(blink_en[0:0]), .brightness(brightness), .seg(seg1),
        .dp(dp1), .an(an1), .frame_done(fd1)
    );

    // Expected registered outputs produced from scan state n cycles after reset release.
    // Packed as {seg[6:0], dp, an[7:0], frame_done}; unused anodes read as 1.
    function automatic logic [16:0] model(input int nd, input int sd, input int bf, input int k,
                                          input logic [31:0] dg, input logic [7:0] dpi,
                                          input logic [7:0] blk, input logic [7:0] ben,
                                          input logic [3:0] br);
        int cnt, slot, idx, frame;
        bit boff, lit;
        logic [3:0] h;
        logic [16:0] r;
        cnt   = k % sd;
        slot  = k / sd;
        idx   = slot % nd;
        frame = slot / nd;
        boff  = ((frame / bf) % 2) == 1;
        lit   = ((cnt / (sd / 16)) <= int'(br)) && !blk[idx] && !(ben[idx] && boff);
        h     = dg[idx*4 +: 4];
        r     = {7'h7F, 1'b1, 8'hFF, (cnt == sd - 1) && (idx == nd - 1)};
        if (lit) begin
            r[16:10]  = hex_tab[h];
            r[9]      = ~dpi[idx];
            r[idx+1]  = 1'b0;
        end
        return r;
    endfunction

    task automatic advance();
        @(posedge clk);
        #1;
        e0 = model(4, 16, 2, n, {16'h0, digits}, {4'h0, dp_in}, {4'h0, blank},
                   {4'h0, blink_en}, brightness);
        e1 = model(1, 32, 2, n, {28'h0, digits[3:0]}, {7'h0, dp_in[0]}, {7'h0, blank[0]},
                   {7'h0, blink_en[0]}, brightness);
        o0 = {seg0, dp0, 4'hF, an0, fd0};
        o1 = {seg1, dp1, 7'h7F, an1, fd1};
        n++;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
    endtask

    task automatic test_reset();
        repeat (40) advance();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({seg0, dp0, an0, fd0} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_async dut4 got=%h exp=%h", {seg0, dp0, an0, fd0},
                     {7'h7F, 1'b1, 4'hF, 1'b0});
        end
        vectors++;
        if ({seg1, dp1, an1, fd1} !== {7'h7F, 1'b1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_async dut1 got=%h exp=%h", {seg1, dp1, an1, fd1},
                     {7'h7F, 1'b1, 1'b1, 1'b0});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        advance();
        vectors++;
        if ({an0, seg0} !== {4'b1110, 7'b1000000}) begin
            miscompares++;
            $display("FAIL reset_first_digit got=%h exp=%h", {an0, seg0}, {4'b1110, 7'b1000000});
        end
    endtask

    task automatic test_scan();
        int fd0_cnt = 0, fd1_cnt = 0;
        digits = 16'h1A90; brightness = 4'hF; blank = '0; blink_en = '0; dp_in = '0;
        for (int i = 0; i < 128; i++) begin
            advance();
            fd0_cnt += int'(fd0);
            fd1_cnt += int'(fd1);
            vectors += 2;
            if (o0 !== e0) begin
                miscompares++;
                $display("FAIL scan dut4 n=%0d got=%h exp=%h", n - 1, o0, e0);
            end
            if (o1 !== e1) begin
                miscompares++;
                $display("FAIL scan dut1 n=%0d got=%h exp=%h", n - 1, o1, e1);
            end
        end
        vectors += 2;
        if (fd0_cnt != 2) begin
            miscompares++;
            $display("FAIL scan_frame_done dut4 got=%0d exp=2", fd0_cnt);
        end
        if (fd1_cnt != 4) begin
            miscompares++;
            $display("FAIL scan_frame_done dut1 got=%0d exp=4", fd1_cnt);
        end
    endtask

    task automatic test_dimming();
        int lit0 = 0, lit1 = 0;
        brightness = 4'd3;
        for (int i = 0; i < 64; i++) begin
            advance();
            lit0 += int'(an0 != 4'hF);
            lit1 += int'(an1 == 1'b0);
            vectors += 2;
            if (o0 !== e0) begin
                miscompares++;
                $display("FAIL dimming dut4 n=%0d got=%h exp=%h", n - 1, o0, e0);
            end
            if (o1 !== e1) begin
                miscompares++;
                $display("FAIL dimming dut1 n=%0d got=%h exp=%h", n - 1, o1, e1);
            end
        end
        vectors += 2;
        if (lit0 != 16) begin
            miscompares++;
            $display("FAIL dimming_duty dut4 got=%0d exp=16", lit0);
        end
        if (lit1 != 16) begin
            miscompares++;
            $display("FAIL dimming_duty dut1 got=%0d exp=16", lit1);
        end
    endtask

    task automatic test_blink();
        int d1_lit = 0;
        brightness = 4'hF; blink_en = 4'b0010;
        do_reset();
        for (int i = 0; i < 384; i++) begin
            advance();
            d1_lit += int'(an0 == 4'b1101);
            vectors += 2;
            if (o0 !== e0) begin
                miscompares++;
                $display("FAIL blink dut4 n=%0d got=%h exp=%h", n - 1, o0, e0);
            end
            if (o1 !== e1) begin
                miscompares++;
                $display("FAIL blink dut1 n=%0d got=%h exp=%h", n - 1, o1, e1);
            end
        end
        vectors++;
        if (d1_lit != 64) begin
            miscompares++;
            $display("FAIL blink_digit1_lit got=%0d exp=64", d1_lit);
        end
        blink_en = '0;
    endtask

    task automatic test_blank_dp();
        int slot2 = 0, dp_low = 0;
        blank = 4'b0100; dp_in = 4'b0001;
        for (int i = 0; i < 128; i++) begin
            advance();
            slot2  += int'(an0 == 4'b1011);
            dp_low += int'(dp0 == 1'b0 && an0 == 4'b1110);
            vectors += 2;
            if (o0 !== e0) begin
                miscompares++;
                $display("FAIL blank_dp dut4 n=%0d got=%h exp=%h", n - 1, o0, e0);
            end
            if (o1 !== e1) begin
                miscompares++;
                $display("FAIL blank_dp dut1 n=%0d got=%h exp=%h", n - 1, o1, e1);
            end
        end
        vectors += 2;
        if (slot2 != 0) begin
            miscompares++;
            $display("FAIL blank_slot2 got=%0d exp=0", slot2);
        end
        if (dp_low != 32) begin
            miscompares++;
            $display("FAIL dp_slot0 got=%0d exp=32", dp_low);
        end
        blank = '0; dp_in = '0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            advance();
            vectors += 3;
            if (o0 !== e0) begin
                miscompares++;
                $display("FAIL random dut4 n=%0d got=%h exp=%h", n - 1, o0, e0);
            end
            if (o1 !== e1) begin
                miscompares++;
                $display("FAIL random dut1 n=%0d got=%h exp=%h", n - 1, o1, e1);
            end
            if ($countones(~an0) > 1) begin
                miscompares++;
                $display("FAIL anode_onehot n=%0d got=%b exp=at most one low", n - 1, an0);
            end
            // Hold inputs for a while sometimes so mid-slot and long-run behaviour both appear.
            if ($urandom_range(3) != 0) begin
                digits     = 16'($urandom);
                dp_in      = 4'($urandom);
                blank      = 4'($urandom) & 4'($urandom);
                blink_en   = 4'($urandom);
                brightness = 4'($urandom);
            end
        end
    endtask

    initial begin
        hex_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
                    7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        test_reset();
        test_scan();
        test_dimming();
        test_blink();
        test_blank_dp();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
